riscv_multicycle: RTL

Parametrised multi-cycle RV32I-subset core that supersedes the single-cycle top for designs sharing one memory port between instruction fetch and data access. A five-state FSM (FETCH, DECODE, EXECUTE, MEM, WB) sequences each instruction over 3–5 cycles through a single request/ready memory handshake that tolerates wait states. Register file, ALU, immediate extension and PC update are internal. Register x10 is exported as `a0` for test observation.

---
 rtl/riscv_multicycle.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multi-cycle RV32I-subset core with one shared memory port.
// Instructions are sequenced through FETCH/DECODE/EXECUTE/MEM/WB. Instruction
// fetches and data accesses use a single request/ready handshake that
// tolerates wait states.
// Optional feature macro: RISCV_MC_TRAP_EN. When it is defined, an undecoded
// opcode parks the core in a TRAP state and the trap output is asserted.
// When it is not defined, an undecoded opcode executes as a NOP.
module riscv_multicycle #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             retire,
    output logic [WIDTH-1:0] a0
`ifdef RISCV_MC_TRAP_EN
    ,
    output logic             trap
`endif
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BNE  = 4'd9,
        OP_JAL  = 4'd10,
        OP_LUI  = 4'd11,
        OP_BAD  = 4'd12
    } op_e;

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};

    // Map a raw instruction word onto the supported operation set.
    function automatic op_e decode_op(input logic [31:0] instr);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        op_e        op;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        op  = OP_BAD;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  op = OP_ADD;
                        3'b111:  op = OP_AND;
                        3'b110:  op = OP_OR;
                        3'b010:  op = OP_SLT;
                        default: op = OP_BAD;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    op = OP_SUB;
                end else begin
                    op = OP_BAD;
                end
            end
            7'b0010011: op = (f3 == 3'b000) ? OP_ADDI : OP_BAD;
            7'b0000011: op = (f3 == 3'b010) ? OP_LW : OP_BAD;
            7'b0100011: op = (f3 == 3'b010) ? OP_SW : OP_BAD;
            7'b1100011: begin
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    default: op = OP_BAD;
                endcase
            end
            7'b1101111: op = OP_JAL;
            7'b0110111: op = OP_LUI;
            default:    op = OP_BAD;
        endcase
        return op;
    endfunction

    // Assemble the format-specific immediate and sign-extend it to WIDTH.
    function automatic logic [WIDTH-1:0] imm_gen(input logic [31:0] instr);
        logic [31:0] raw;
        raw = 32'h0000_0000;
        case (instr[6:0])
            7'b0010011, 7'b0000011: raw = {{20{instr[31]}}, instr[31:20]};
            7'b0100011: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011: raw = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            7'b1101111: raw = {{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            7'b0110111: raw = {instr[31:12], 12'h000};
            default:    raw = 32'h0000_0000;
        endcase
        return WIDTH'($signed(raw));
    endfunction

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] pc_q;
    logic [31:0]      ir_q;
    logic [WIDTH-1:0] rs1_q;
    logic [WIDTH-1:0] rs2_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] rf_q [0:31];

    op_e              dec_op_s;
    logic [WIDTH-1:0] dec_imm_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] pc_target_s;
    logic             br_taken_s;
    logic [4:0]       rd_s;

    assign dec_op_s    = decode_op(ir_q);
    assign dec_imm_s   = imm_gen(ir_q);
    assign pc_plus4_s  = pc_q + PC_STEP;
    assign pc_target_s = pc_q + imm_q;
    assign rd_s        = ir_q[11:7];
    assign br_taken_s  = ((op_q == OP_BEQ) && (rs1_q == rs2_q)) ||
                         ((op_q == OP_BNE) && (rs1_q != rs2_q));

    // ALU: result for the EXECUTE stage (also the lw/sw effective address).
    always_comb begin
        res_d = '0;
        case (op_q)
            OP_ADD:  res_d = rs1_q + rs2_q;
            OP_SUB:  res_d = rs1_q - rs2_q;
            OP_AND:  res_d = rs1_q & rs2_q;
            OP_OR:   res_d = rs1_q | rs2_q;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(rs1_q) < $signed(rs2_q))};
            OP_ADDI, OP_LW, OP_SW: res_d = rs1_q + imm_q;
            OP_JAL:  res_d = pc_plus4_s;
            OP_LUI:  res_d = imm_q;
            default: res_d = '0;
        endcase
    end

    // Instruction sequencer and datapath registers (state, pc, operands, result).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
            op_q    <= OP_BAD;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata[31:0];
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_q  <= dec_op_s;
                    rs1_q <= rf_q[ir_q[19:15]];
                    rs2_q <= rf_q[ir_q[24:20]];
                    imm_q <= dec_imm_s;
`ifdef RISCV_MC_TRAP_EN
                    if (dec_op_s == OP_BAD) begin
                        state_q <= S_TRAP;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
`else
                    state_q <= S_EXECUTE;
`endif
                end
                S_EXECUTE: begin
                    res_q <= res_d;
                    case (op_q)
                        OP_BEQ, OP_BNE: begin
                            pc_q    <= br_taken_s ? pc_target_s : pc_plus4_s;
                            state_q <= S_FETCH;
                        end
                        OP_JAL: begin
                            pc_q    <= pc_target_s;
                            state_q <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            state_q <= S_MEM;
                        end
                        OP_BAD: begin
                            pc_q    <= pc_plus4_s;
                            state_q <= S_FETCH;
                        end
                        default: begin
                            pc_q    <= pc_plus4_s;
                            state_q <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        pc_q <= pc_plus4_s;
                        if (op_q == OP_LW) begin
                            res_q   <= mem_rdata;
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Register file: cleared on reset, written in WB; x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (state_q == S_WB && rd_s != 5'd0) begin
            rf_q[rd_s] <= res_q;
        end
    end

    // Memory port and retire pulse decoded from state; forced low while in reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = (op_q == OP_SW);
                    mem_addr  = res_q;
                    mem_wdata = rs2_q;
                    retire    = mem_ready && (op_q == OP_SW);
                end
                S_EXECUTE: begin
                    retire = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_BAD);
                end
                S_WB: begin
                    retire = 1'b1;
                end
                default: begin
                    retire = 1'b0;
                end
            endcase
        end else begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            retire    = 1'b0;
        end
    end

    assign a0 = rf_q[10];

`ifdef RISCV_MC_TRAP_EN
    assign trap = (state_q == S_TRAP);
`endif

endmodule
